// File: rtl/rom_ctrl_pkg.sv
// rtl/rom_ctrl_pkg.sv - shared state encoding and requester port indices for the ROM access controller
package rom_ctrl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rom_access_ctrl_if.sv
// rtl/rom_access_ctrl_if.sv - requester and ROM-side signal bundle for rom_access_ctrl
interface rom_access_ctrl_if #(
    parameter int ADDR_SIZE = 12,
    parameter int WORD_SIZE = 16
);

    logic                 f_req;
    logic [ADDR_SIZE-1:0] f_addr;
    logic                 f_gnt;
    logic                 f_rvalid;
    logic [WORD_SIZE-1:0] f_rdata;

    logic                 d_req;
    logic [ADDR_SIZE-1:0] d_addr;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [WORD_SIZE-1:0] d_rdata;

    logic [ADDR_SIZE-1:0] rom_a;
    logic [WORD_SIZE-1:0] rom_q;
    logic                 busy;

    // master: the requesters plus the ROM macro; slave: the controller
    modport master (
        output f_req, f_addr, d_req, d_addr, rom_q,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, rom_a, busy
    );

    modport slave (
        input  f_req, f_addr, d_req, d_addr, rom_q,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, rom_a, busy
    );

endinterface

// File: rtl/rom_arb_sel.sv
// rtl/rom_arb_sel.sv - combinational winner select; ROM_ARB_RR_EN enables round-robin, else F beats D
module rom_arb_sel
    import rom_ctrl_pkg::*;
(
    input  logic f_req,
    input  logic d_req,
`ifdef ROM_ARB_RR_EN
    input  logic last_gnt,
`endif
    output logic win_valid,
    output logic win_port
);

    always_comb begin
        win_valid = f_req | d_req;
`ifdef ROM_ARB_RR_EN
        // on a tie, the port that did not win last time goes first
        if (f_req && d_req) begin
            win_port = ~last_gnt;
        end else begin
            win_port = f_req ? PORT_F : PORT_D;
        end
`else
        win_port = f_req ? PORT_F : PORT_D;
`endif
    end

endmodule

// File: rtl/rom_access_ctrl.sv
// rtl/rom_access_ctrl.sv - shares one async-read ROM between fetch and data requesters (ROM_ARB_RR_EN: round-robin)
module rom_access_ctrl
    import rom_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 12,
    parameter int WORD_SIZE = 16
) (
    input  logic              clk,
    input  logic              rst,
    rom_access_ctrl_if.slave  bus
);

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] rom_a_q, rom_a_d;
    logic                 owner_q, owner_d;
    logic                 f_gnt_q, f_gnt_d;
    logic                 d_gnt_q, d_gnt_d;
    logic                 f_rvalid_q, f_rvalid_d;
    logic                 d_rvalid_q, d_rvalid_d;
    logic                 busy_q, busy_d;
    logic [WORD_SIZE-1:0] f_rdata_q, f_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
`ifdef ROM_ARB_RR_EN
    logic                 last_q, last_d;
`endif

    logic win_valid;
    logic win_port;

    rom_arb_sel u_arb (
        .f_req     (bus.f_req),
        .d_req     (bus.d_req),
`ifdef ROM_ARB_RR_EN
        .last_gnt  (last_q),
`endif
        .win_valid (win_valid),
        .win_port  (win_port)
    );

    always_comb begin
        state_d    = state_q;
        rom_a_d    = rom_a_q;
        owner_d    = owner_q;
        f_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        f_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        busy_d     = 1'b0;
        f_rdata_d  = f_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ROM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    rom_a_d = (win_port == PORT_D) ? bus.d_addr : bus.f_addr;
                    owner_d = win_port;
                    f_gnt_d = (win_port == PORT_F);
                    d_gnt_d = (win_port == PORT_D);
                    busy_d  = 1'b1;
                    state_d = ST_ACCESS;
`ifdef ROM_ARB_RR_EN
                    last_d  = win_port;
`endif
                end
            end
            ST_ACCESS: begin
                // rom_q has settled from the address registered at the previous edge
                if (owner_q == PORT_D) begin
                    d_rdata_d  = bus.rom_q;
                    d_rvalid_d = 1'b1;
                end else begin
                    f_rdata_d  = bus.rom_q;
                    f_rvalid_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rom_a_q    <= '0;
            owner_q    <= PORT_F;
            f_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            busy_q     <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
`ifdef ROM_ARB_RR_EN
            last_q     <= PORT_D;
`endif
        end else begin
            state_q    <= state_d;
            rom_a_q    <= rom_a_d;
            owner_q    <= owner_d;
            f_gnt_q    <= f_gnt_d;
            d_gnt_q    <= d_gnt_d;
            f_rvalid_q <= f_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            busy_q     <= busy_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef ROM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.rom_a    = rom_a_q;
    assign bus.f_gnt    = f_gnt_q;
    assign bus.d_gnt    = d_gnt_q;
    assign bus.f_rvalid = f_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.f_rdata  = f_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rom_access_ctrl.sv
// tb/tb_rom_access_ctrl.sv - scoreboard bench for rom_access_ctrl with a behavioural async ROM
module tb_rom_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rom_access_ctrl_if #(.ADDR_SIZE(12), .WORD_SIZE(16)) bus ();

    rom_access_ctrl #(.ADDR_SIZE(12), .WORD_SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [4096];
    assign #2 bus.rom_q = mem[bus.rom_a];

    int checks = 0;
    int errors = 0;

    logic [11:0] f_pend[$], d_pend[$];
    logic [11:0] f_exp_addr[$], d_exp_addr[$];
    logic [15:0] f_exp_data[$], d_exp_data[$];
    bit          gnt_log[$];
    bit          exp_log[$];
    logic [15:0] f_hold = '0, d_hold = '0;
    bit          f_gnt_prev = 0, d_gnt_prev = 0;
    bit          drv_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic enq(input bit port, input logic [11:0] a, input logic [15:0] dat);
        if (port) begin
            d_pend.push_back(a); d_exp_addr.push_back(a); d_exp_data.push_back(dat);
        end else begin
            f_pend.push_back(a); f_exp_addr.push_back(a); f_exp_data.push_back(dat);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((f_pend.size() + d_pend.size() + f_exp_data.size() + d_exp_data.size()) != 0
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("drain_timeout", n, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, gnt_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < gnt_log.size(); i++)
            chk({name, "_order"}, {24'd0, i[7:0]} << 1 | gnt_log[i], {24'd0, i[7:0]} << 1 | exp_log[i]);
        gnt_log.delete();
        exp_log.delete();
    endtask

    // requester model: hold req/addr until gnt, then move on in the following cycle
    initial forever begin
        @(posedge clk);
        #1;
        if (drv_en) begin
            if (bus.f_gnt && f_pend.size() != 0) void'(f_pend.pop_front());
            if (bus.d_gnt && d_pend.size() != 0) void'(d_pend.pop_front());
            bus.f_req  = (f_pend.size() != 0);
            bus.f_addr = (f_pend.size() != 0) ? f_pend[0] : 12'h000;
            bus.d_req  = (d_pend.size() != 0);
            bus.d_addr = (d_pend.size() != 0) ? d_pend[0] : 12'h000;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.f_rvalid && bus.d_rvalid) chk("both_rvalid", 1, 0);
            if (bus.f_gnt && bus.d_gnt) chk("both_gnt", 1, 0);
            if (bus.f_gnt) begin
                gnt_log.push_back(1'b0);
                chk("busy_with_f_gnt", bus.busy, 1);
                if (f_exp_addr.size() == 0) chk("unexpected_f_gnt", 1, 0);
                else chk("f_rom_a", bus.rom_a, f_exp_addr.pop_front());
            end
            if (bus.d_gnt) begin
                gnt_log.push_back(1'b1);
                chk("busy_with_d_gnt", bus.busy, 1);
                if (d_exp_addr.size() == 0) chk("unexpected_d_gnt", 1, 0);
                else chk("d_rom_a", bus.rom_a, d_exp_addr.pop_front());
            end
            if (bus.f_rvalid) begin
                chk("f_latency", f_gnt_prev, 1);
                chk("d_rdata_unchanged", bus.d_rdata, d_hold);
                if (f_exp_data.size() == 0) chk("unexpected_f_rvalid", 1, 0);
                else begin
                    f_hold = f_exp_data.pop_front();
                    chk("f_rdata", bus.f_rdata, f_hold);
                end
            end
            if (bus.d_rvalid) begin
                chk("d_latency", d_gnt_prev, 1);
                chk("f_rdata_unchanged", bus.f_rdata, f_hold);
                if (d_exp_data.size() == 0) chk("unexpected_d_rvalid", 1, 0);
                else begin
                    d_hold = d_exp_data.pop_front();
                    chk("d_rdata", bus.d_rdata, d_hold);
                end
            end
            f_gnt_prev = bus.f_gnt;
            d_gnt_prev = bus.d_gnt;
        end
    end

    initial begin
        int cyc;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h000] = 16'h0F0F;
        mem[12'h010] = 16'hA5A5;
        mem[12'h020] = 16'h1111;
        mem[12'h030] = 16'h2222;
        mem[12'h040] = 16'h4040;
        mem[12'hFFF] = 16'hBEEF;
        for (int i = 0; i < 8; i++) mem[12'h100 + i] = 16'hF000 + 16'(i);
        for (int i = 0; i < 4; i++) mem[12'h200 + i] = 16'hD000 + 16'(i);

        bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_addr = '0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // reset then idle
        @(negedge clk);
        chk("reset_rom_a", bus.rom_a, 0);
        chk("reset_f_rdata", bus.f_rdata, 0);
        chk("reset_d_rdata", bus.d_rdata, 0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_outputs", {bus.f_gnt, bus.d_gnt, bus.f_rvalid, bus.d_rvalid, bus.busy}, 0);
            @(negedge clk);
        end
        drv_en = 1;

        // single fetch
        enq(0, 12'h010, 16'hA5A5);
        drain(50);
        chk("single_f_rdata_held", bus.f_rdata, 16'hA5A5);
        chk("single_d_rdata_zero", bus.d_rdata, 0);
        exp_log = '{1'b0};
        check_log("single");

        // simultaneous F and D
        enq(0, 12'h020, 16'h1111);
        enq(1, 12'h030, 16'h2222);
        drain(50);
        chk("sim_f_rdata", bus.f_rdata, 16'h1111);
        chk("sim_d_rdata", bus.d_rdata, 16'h2222);
        exp_log = '{1'b0, 1'b1};
        check_log("sim");

        // continuous F traffic with D pending (last grant was D)
        for (int i = 0; i < 8; i++) enq(0, 12'h100 + 12'(i), 16'hF000 + 16'(i));
        for (int i = 0; i < 4; i++) enq(1, 12'h200 + 12'(i), 16'hD000 + 16'(i));
        drain(200);
`ifdef ROM_ARB_RR_EN
        exp_log = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
`else
        exp_log = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`endif
        check_log("stream");

        // reset during ACCESS
        drv_en = 0;
        f_exp_addr.push_back(12'h040);
        bus.f_req = 1; bus.f_addr = 12'h040;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.f_gnt && cyc < 20);
        chk("abort_gnt_seen", bus.f_gnt, 1);
        #1;
        rst = 1;
        bus.f_req = 0;
        @(posedge clk);
        #1 rst = 0;
        f_hold = '0;
        d_hold = '0;
        @(negedge clk);
        chk("abort_no_rvalid", {bus.f_rvalid, bus.d_rvalid}, 0);
        chk("abort_f_rdata", bus.f_rdata, 0);
        chk("abort_d_rdata", bus.d_rdata, 0);
        chk("abort_busy", bus.busy, 0);
        f_exp_addr.delete();
        gnt_log.delete();
        drv_en = 1;
        enq(0, 12'h040, 16'h4040);
        drain(50);
        chk("reissue_f_rdata", bus.f_rdata, 16'h4040);

        // address wrap
        enq(0, 12'hFFF, 16'hBEEF);
        enq(0, 12'h000, 16'h0F0F);
        drain(50);
        chk("wrap_f_rdata", bus.f_rdata, 16'h0F0F);
        exp_log = '{1'b0, 1'b0, 1'b0};
        check_log("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
